// File: rtl/neureka_tcdm_responder_pkg.sv
// Shared types and constants for the TCDM responder.
//   - NEUREKA_MEM_BANDWIDTH_EXT / ID_WIDTH: default data and id widths
//   - NEUREKA_TCDM_RESP_MAX_LAT: deepest supported response pipeline
//   - NEUREKA_TCDM_LFSR_TAPS + neureka_tcdm_lfsr_next(): stall generator LFSR
//   - neureka_tcdm_resp_t: one response pipeline stage {valid, id, data}
package neureka_tcdm_responder_pkg;

    localparam int unsigned NEUREKA_MEM_BANDWIDTH_EXT = 256;
    localparam int unsigned ID_WIDTH                  = 8;
    localparam int unsigned NEUREKA_TCDM_RESP_MAX_LAT = 4;

    // x^16 + x^14 + x^13 + x^11 + 1 on a right-shifting register: the feedback
    // bit is the XOR of bits 0, 2, 3 and 5 and enters at bit 15.
    localparam logic [15:0] NEUREKA_TCDM_LFSR_TAPS = 16'h002D;

    // Sized for the widest configuration; narrower instances use the low bits.
    typedef struct packed {
        logic                                 r_valid;
        logic [ID_WIDTH-1:0]                  r_id;
        logic [NEUREKA_MEM_BANDWIDTH_EXT-1:0] r_data;
    } neureka_tcdm_resp_t;

    function automatic logic [15:0] neureka_tcdm_lfsr_next(input logic [15:0] state);
        return {^(state & NEUREKA_TCDM_LFSR_TAPS), state[15:1]};
    endfunction

endpackage

// File: rtl/neureka_tcdm_responder_mem.sv
// Single-port, byte-enabled scratch memory with a registered read port.
// Kept as its own module so it can be replaced by an SRAM macro.
//   clk_i   : clock
//   req_i   : access enable (read or write)
//   we_i    : 1 = write, 0 = read
//   addr_i  : word index
//   be_i    : byte enables for writes
//   wdata_i : write data
//   rdata_o : read data, valid the cycle after a read access
module neureka_tcdm_responder_mem
    import neureka_tcdm_responder_pkg::*;
#(
    parameter int unsigned DW    = NEUREKA_MEM_BANDWIDTH_EXT,
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clk_i,
    input  logic                     req_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [DW/8-1:0]          be_i,
    input  logic [DW-1:0]            wdata_i,
    output logic [DW-1:0]            rdata_o
);

    // Contents deliberately have no reset so they survive a logic reset.
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (req_i) begin
            if (we_i) begin
                for (int unsigned b = 0; b < DW / 8; b++) begin
                    if (be_i[b]) begin
                        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/neureka_tcdm_responder.sv
// Memory-side responder closing the TCDM load/store protocol for benches.
// Grants requests (optionally with pseudo-random stalls), applies
// byte-enabled writes, and returns reads after exactly LATENCY cycles.
//   clk_i / rst_i      : clock, asynchronous active-high reset
//   tcdm_req_i/gnt_o   : request handshake; gnt depends only on req and the LFSR
//   tcdm_add_i         : byte address
//   tcdm_wen_i         : 1 = read, 0 = write
//   tcdm_be_i/data_i   : write byte enables and data
//   tcdm_id_i          : request id, echoed on read responses
//   tcdm_r_valid_o     : one-cycle read response pulse with r_data_o / r_id_o
//   err_o              : sticky out-of-range access flag
//   n_rd_o / n_wr_o    : saturating counts of accepted reads / writes
module neureka_tcdm_responder
    import neureka_tcdm_responder_pkg::*;
#(
    parameter int unsigned DW       = NEUREKA_MEM_BANDWIDTH_EXT,
    parameter int unsigned AW       = 32,
    parameter int unsigned IW       = ID_WIDTH,
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned LATENCY  = 1,
    parameter bit          STALL_EN = 1'b0,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            tcdm_req_i,
    output logic            tcdm_gnt_o,
    input  logic [AW-1:0]   tcdm_add_i,
    input  logic            tcdm_wen_i,
    input  logic [DW/8-1:0] tcdm_be_i,
    input  logic [DW-1:0]   tcdm_data_i,
    input  logic [IW-1:0]   tcdm_id_i,
    output logic            tcdm_r_valid_o,
    output logic [DW-1:0]   tcdm_r_data_o,
    output logic [IW-1:0]   tcdm_r_id_o,
    output logic            err_o,
    output logic [31:0]     n_rd_o,
    output logic [31:0]     n_wr_o
);

    localparam int unsigned OFS  = $clog2(DW / 8);
    localparam int unsigned IDXW = $clog2(DEPTH);

    // Elaboration-time parameter checks. The byte offset is a plain bit slice,
    // so the word size in bytes must be a power of two.
    if (LATENCY < 1 || LATENCY > NEUREKA_TCDM_RESP_MAX_LAT) begin : g_bad_latency
        $error("LATENCY must be in 1..%0d", NEUREKA_TCDM_RESP_MAX_LAT);
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two >= 2");
    end
    if (DW < 8 || DW % 8 != 0 || ((DW / 8) & (DW / 8 - 1)) != 0 ||
        DW > NEUREKA_MEM_BANDWIDTH_EXT) begin : g_bad_dw
        $error("DW must be a power-of-two number of bytes, at most the package width");
    end
    if (IW < 1 || IW > ID_WIDTH) begin : g_bad_iw
        $error("IW must be in 1..ID_WIDTH");
    end
    if (AW <= OFS + IDXW) begin : g_bad_aw
        $error("AW too small to hold the byte offset and word index");
    end
    if (SEED == 16'h0) begin : g_bad_seed
        $error("SEED must be non-zero");
    end

    logic [15:0]     lfsr_q, lfsr_d;
    logic            stall;
    logic            rd_acc, wr_acc;
    logic            out_of_range;
    logic [IDXW-1:0] word_idx;
    logic            unused_add_ofs;
    logic [DW-1:0]   mem_rdata;

    logic            s1_valid_q, s1_valid_d;
    logic            s1_oor_q, s1_oor_d;
    logic [IW-1:0]   s1_id_q, s1_id_d;
    logic            err_q, err_d;
    logic [31:0]     n_rd_q, n_rd_d;
    logic [31:0]     n_wr_q, n_wr_d;

    neureka_tcdm_resp_t s1_resp;
    neureka_tcdm_resp_t resp_out;

    assign stall      = STALL_EN && (lfsr_q[3:0] == 4'd0);
    assign tcdm_gnt_o = tcdm_req_i & ~stall;
    assign rd_acc     = tcdm_gnt_o & tcdm_wen_i;
    assign wr_acc     = tcdm_gnt_o & ~tcdm_wen_i;

    assign word_idx     = tcdm_add_i[OFS +: IDXW];
    assign out_of_range = |tcdm_add_i[AW-1:OFS+IDXW];
    // Byte-offset bits inside a word carry no information here.
    assign unused_add_ofs = ^tcdm_add_i[(OFS > 0 ? OFS - 1 : 0):0];

    neureka_tcdm_responder_mem #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk_i),
        .req_i   ((rd_acc | wr_acc) & ~out_of_range),
        .we_i    (~tcdm_wen_i),
        .addr_i  (word_idx),
        .be_i    (tcdm_be_i),
        .wdata_i (tcdm_data_i),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        lfsr_d     = neureka_tcdm_lfsr_next(lfsr_q);
        s1_valid_d = rd_acc;
        s1_oor_d   = rd_acc & out_of_range;
        s1_id_d    = rd_acc ? tcdm_id_i : '0;
        err_d      = err_q | ((rd_acc | wr_acc) & out_of_range);
        n_rd_d     = n_rd_q;
        n_wr_d     = n_wr_q;
        if (rd_acc && (n_rd_q != 32'hFFFF_FFFF)) begin
            n_rd_d = n_rd_q + 32'd1;
        end
        if (wr_acc && (n_wr_q != 32'hFFFF_FFFF)) begin
            n_wr_d = n_wr_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q     <= SEED;
            s1_valid_q <= 1'b0;
            s1_oor_q   <= 1'b0;
            s1_id_q    <= '0;
            err_q      <= 1'b0;
            n_rd_q     <= '0;
            n_wr_q     <= '0;
        end else begin
            lfsr_q     <= lfsr_d;
            s1_valid_q <= s1_valid_d;
            s1_oor_q   <= s1_oor_d;
            s1_id_q    <= s1_id_d;
            err_q      <= err_d;
            n_rd_q     <= n_rd_d;
            n_wr_q     <= n_wr_d;
        end
    end

    // Stage 1 is the registered memory read. The raw SRAM output is not reset
    // and goes stale between reads, so data is masked unless a valid in-range
    // response occupies the stage.
    always_comb begin
        s1_resp              = '0;
        s1_resp.r_valid      = s1_valid_q;
        s1_resp.r_id[IW-1:0] = s1_id_q;
        if (s1_valid_q && !s1_oor_q) begin
            s1_resp.r_data[DW-1:0] = mem_rdata;
        end
    end

    if (LATENCY == 1) begin : g_lat1
        assign resp_out = s1_resp;
    end else begin : g_latn
        neureka_tcdm_resp_t pipe_q [LATENCY-1];
        neureka_tcdm_resp_t pipe_d [LATENCY-1];

        always_comb begin
            pipe_d[0] = s1_resp;
            for (int i = 1; i < int'(LATENCY) - 1; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int i = 0; i < int'(LATENCY) - 1; i++) begin
                    pipe_q[i] <= '0;
                end
            end else begin
                pipe_q <= pipe_d;
            end
        end

        assign resp_out = pipe_q[LATENCY-2];
    end

    assign tcdm_r_valid_o = resp_out.r_valid;
    assign tcdm_r_id_o    = resp_out.r_id[IW-1:0];
    assign tcdm_r_data_o  = resp_out.r_data[DW-1:0];
    assign err_o          = err_q;
    assign n_rd_o         = n_rd_q;
    assign n_wr_o         = n_wr_q;

endmodule

// File: tb/tb_neureka_tcdm_responder.sv
// Scoreboard bench for neureka_tcdm_responder.
// dut 0: LATENCY=3, no stalls (directed data, back-to-back, out-of-range).
// dut 1: LATENCY=4, stalls on (grant model, traffic under stall, reset).
module tb_neureka_tcdm_responder;
    import neureka_tcdm_responder_pkg::*;

    localparam int unsigned DW    = NEUREKA_MEM_BANDWIDTH_EXT;
    localparam int unsigned BW    = DW / 8;
    localparam int unsigned IW    = ID_WIDTH;
    localparam int unsigned DEPTH = 1024;
    localparam int          LAT0  = 3;
    localparam int          LAT1  = 4;

    logic          clk = 1'b0;
    logic          rst0, rst1;
    logic          req [2];
    logic          gnt [2];
    logic          wen [2];
    logic          r_valid [2];
    logic          err [2];
    logic [31:0]   add [2];
    logic [BW-1:0] be [2];
    logic [DW-1:0] wdata [2];
    logic [DW-1:0] r_data [2];
    logic [IW-1:0] id [2];
    logic [IW-1:0] r_id [2];
    logic [31:0]   n_rd [2];
    logic [31:0]   n_wr [2];

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    int          cyc    = 0;
    int          nchk   = 0;
    int          nerr   = 0;
    int          nstall = 0;
    logic [15:0] m_lfsr;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    neureka_tcdm_responder #(
        .DW(DW), .AW(32), .IW(IW), .DEPTH(DEPTH), .LATENCY(LAT0), .STALL_EN(1'b0),
        .SEED(16'hACE1)
    ) u_dut0 (
        .clk_i(clk), .rst_i(rst0), .tcdm_req_i(req[0]), .tcdm_gnt_o(gnt[0]),
        .tcdm_add_i(add[0]), .tcdm_wen_i(wen[0]), .tcdm_be_i(be[0]), .tcdm_data_i(wdata[0]),
        .tcdm_id_i(id[0]), .tcdm_r_valid_o(r_valid[0]), .tcdm_r_data_o(r_data[0]),
        .tcdm_r_id_o(r_id[0]), .err_o(err[0]), .n_rd_o(n_rd[0]), .n_wr_o(n_wr[0])
    );

    neureka_tcdm_responder #(
        .DW(DW), .AW(32), .IW(IW), .DEPTH(DEPTH), .LATENCY(LAT1), .STALL_EN(1'b1),
        .SEED(16'hACE1)
    ) u_dut1 (
        .clk_i(clk), .rst_i(rst1), .tcdm_req_i(req[1]), .tcdm_gnt_o(gnt[1]),
        .tcdm_add_i(add[1]), .tcdm_wen_i(wen[1]), .tcdm_be_i(be[1]), .tcdm_data_i(wdata[1]),
        .tcdm_id_i(id[1]), .tcdm_r_valid_o(r_valid[1]), .tcdm_r_data_o(r_data[1]),
        .tcdm_r_id_o(r_id[1]), .err_o(err[1]), .n_rd_o(n_rd[1]), .n_wr_o(n_wr[1])
    );

    task automatic check(input string name, input logic ok, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        nchk++;
        if (ok !== 1'b1) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input logic [15:0] tag, input int i);
        return {8{tag, 16'(i)}};
    endfunction

    function automatic int lat(input int k);
        return (k == 0) ? LAT0 : LAT1;
    endfunction

    // Reference stall generator: x^16+x^14+x^13+x^11+1, shifting right.
    always @(posedge clk or posedge rst1) begin
        if (rst1) m_lfsr <= 16'hACE1;
        else      m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

    always @(negedge clk) begin
        if (!rst0 && req[0]) check("gnt0", gnt[0] === 1'b1, DW'(gnt[0]), DW'(1));
        if (!rst1 && req[1]) begin
            check("gnt1_lfsr", gnt[1] === (m_lfsr[3:0] != 4'd0), DW'(gnt[1]),
                  DW'(m_lfsr[3:0] != 4'd0));
            if (gnt[1] === 1'b0) nstall++;
        end
    end

    // Response monitor: pops the scoreboard whenever a DUT presents r_valid.
    always @(negedge clk) begin
        exp_t e;
        if (r_valid[0] === 1'b1) begin
            if (q0.size() == 0) begin
                check("resp0_unexpected", 1'b0, DW'(r_id[0]), '0);
            end else begin
                e = q0.pop_front();
                check("resp0_id", r_id[0] === e.id, DW'(r_id[0]), DW'(e.id));
                check("resp0_data", r_data[0] === e.data, r_data[0], e.data);
                check("resp0_cycle", cyc == e.due, DW'(cyc), DW'(e.due));
            end
        end
        while (q0.size() > 0 && q0[0].due < cyc) begin
            check("resp0_lost", 1'b0, DW'(q0[0].id), DW'(q0[0].due));
            void'(q0.pop_front());
        end
        if (r_valid[1] === 1'b1) begin
            if (q1.size() == 0) begin
                check("resp1_unexpected", 1'b0, DW'(r_id[1]), '0);
            end else begin
                e = q1.pop_front();
                check("resp1_id", r_id[1] === e.id, DW'(r_id[1]), DW'(e.id));
                check("resp1_data", r_data[1] === e.data, r_data[1], e.data);
                check("resp1_cycle", cyc == e.due, DW'(cyc), DW'(e.due));
            end
        end
        while (q1.size() > 0 && q1[0].due < cyc) begin
            check("resp1_lost", 1'b0, DW'(q1[0].id), DW'(q1[0].due));
            void'(q1.pop_front());
        end
    end

    // Called just after a rising edge; holds the request until granted and
    // returns just after the accepting edge with req still high.
    task automatic issue(input int k, input logic is_rd, input logic [31:0] a,
                         input logic [BW-1:0] be_v, input logic [DW-1:0] wd,
                         input logic [IW-1:0] id_v, input logic [DW-1:0] exp_v);
        exp_t e;
        logic done;
        done   = 1'b0;
        req[k] = 1'b1;
        wen[k] = is_rd;
        add[k] = a;
        be[k]  = be_v;
        wdata[k] = wd;
        id[k]  = id_v;
        for (int t = 0; t < 40 && !done; t++) begin
            @(negedge clk);
            if (gnt[k] === 1'b1) begin
                done = 1'b1;
                if (is_rd) begin
                    e.id   = id_v;
                    e.data = exp_v;
                    e.due  = cyc + lat(k);
                    if (k == 0) q0.push_back(e);
                    else        q1.push_back(e);
                end
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("grant_timeout", 1'b0, DW'(a), DW'(id_v));
    endtask

    task automatic idle(input int k, input int n);
        req[k] = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int n;
        for (int k = 0; k < 2; k++) begin
            req[k] = 1'b0; wen[k] = 1'b1; add[k] = '0; be[k] = '0; wdata[k] = '0; id[k] = '0;
        end
        rst0 = 1'b1;
        rst1 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst0 = 1'b0;
        rst1 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_rvalid%0d", k), r_valid[k] === 1'b0, DW'(r_valid[k]), '0);
            check($sformatf("rst_rdata%0d", k), r_data[k] === '0, r_data[k], '0);
            check($sformatf("rst_rid%0d", k), r_id[k] === '0, DW'(r_id[k]), '0);
            check($sformatf("rst_err%0d", k), err[k] === 1'b0, DW'(err[k]), '0);
            check($sformatf("rst_nrd%0d", k), n_rd[k] === '0, DW'(n_rd[k]), '0);
            check($sformatf("rst_nwr%0d", k), n_wr[k] === '0, DW'(n_wr[k]), '0);
        end
        @(posedge clk);
        #1;

        // Write then read the next cycle (read-after-write), latency 3.
        issue(0, 1'b0, 32'h40, '1, {BW{8'hA5}}, 8'h01, '0);
        issue(0, 1'b1, 32'h40, '0, '0, 8'h12, {BW{8'hA5}});
        idle(0, 5);
        check("cnt_wr_1", n_wr[0] === 32'd1, DW'(n_wr[0]), DW'(1));
        check("cnt_rd_1", n_rd[0] === 32'd1, DW'(n_rd[0]), DW'(1));

        // Byte enables on word 2 (byte address 0x40); 0x5F hits the same word.
        issue(0, 1'b0, 32'h40, '1, {BW{8'h11}}, 8'h02, '0);
        issue(0, 1'b0, 32'h40, 32'h0000_0005, {BW{8'hFF}}, 8'h03, '0);
        issue(0, 1'b1, 32'h40, '0, '0, 8'h21, {{29{8'h11}}, 8'hFF, 8'h11, 8'hFF});
        issue(0, 1'b1, 32'h5F, '0, '0, 8'h22, {{29{8'h11}}, 8'hFF, 8'h11, 8'hFF});
        idle(0, 5);

        // 64 writes, then 64 back-to-back reads with no bubbles.
        for (int i = 0; i < 64; i++) issue(0, 1'b0, 32'(i * 32), '1, pat(16'hC0DE, i), 8'(i), '0);
        c0 = cyc;
        for (int i = 0; i < 64; i++) issue(0, 1'b1, 32'(i * 32), '0, '0, 8'(i), pat(16'hC0DE, i));
        check("b2b_cycles", (cyc - c0) == 64, DW'(cyc - c0), DW'(64));
        idle(0, 6);
        check("cnt_wr_67", n_wr[0] === 32'd67, DW'(n_wr[0]), DW'(67));
        check("cnt_rd_67", n_rd[0] === 32'd67, DW'(n_rd[0]), DW'(67));

        // Highest in-range word.
        issue(0, 1'b0, 32'h7FE0, '1, pat(16'h7FE0, 1023), 8'h30, '0);
        issue(0, 1'b1, 32'h7FE0, '0, '0, 8'h33, pat(16'h7FE0, 1023));
        idle(0, 5);
        check("err_clear", err[0] === 1'b0, DW'(err[0]), '0);

        // Out of range: first address past the end, and a high address bit.
        issue(0, 1'b1, 32'h8000, '0, '0, 8'h77, '0);
        idle(0, 5);
        check("err_set", err[0] === 1'b1, DW'(err[0]), DW'(1));
        issue(0, 1'b1, 32'h8000_0040, '0, '0, 8'h7A, '0);
        idle(0, 10);
        check("err_held", err[0] === 1'b1, DW'(err[0]), DW'(1));
        issue(0, 1'b0, 32'h8000, '1, {BW{8'hEE}}, 8'h78, '0);
        issue(0, 1'b1, 32'h0, '0, '0, 8'h79, pat(16'hC0DE, 0));
        idle(0, 5);

        // Stalling instance: fill 16 words, then ~1000 cycles of continuous reads.
        for (int i = 0; i < 16; i++) issue(1, 1'b0, 32'(i * 32), '1, pat(16'hBEEF, i), 8'(i), '0);
        c0 = cyc;
        n  = 0;
        while (cyc - c0 < 1000) begin
            issue(1, 1'b1, 32'((n % 16) * 32), '0, '0, 8'(n), pat(16'hBEEF, n % 16));
            n++;
        end
        idle(1, 8);
        check("stall_seen", nstall > 0, DW'(nstall), DW'(1));

        // Reset with two reads in flight: both are discarded, memory survives.
        issue(1, 1'b1, 32'(5 * 32), '0, '0, 8'hA1, pat(16'hBEEF, 5));
        issue(1, 1'b1, 32'(6 * 32), '0, '0, 8'hA2, pat(16'hBEEF, 6));
        req[1] = 1'b0;
        rst1   = 1'b1;
        q1.delete();
        repeat (2) begin
            @(negedge clk);
            check("rst_mid_rvalid", r_valid[1] === 1'b0, DW'(r_valid[1]), '0);
        end
        rst1 = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("post_rst_rvalid", r_valid[1] === 1'b0, DW'(r_valid[1]), '0);
        end
        check("post_rst_nrd", n_rd[1] === '0, DW'(n_rd[1]), '0);
        check("post_rst_nwr", n_wr[1] === '0, DW'(n_wr[1]), '0);
        check("post_rst_err", err[1] === 1'b0, DW'(err[1]), '0);
        @(posedge clk);
        #1;
        issue(1, 1'b1, 32'(5 * 32), '0, '0, 8'hA3, pat(16'hBEEF, 5));
        idle(1, 8);

        for (int t = 0; t < 20 && (q0.size() != 0 || q1.size() != 0); t++) @(posedge clk);
        @(negedge clk);
        check("sb0_empty", q0.size() == 0, DW'(q0.size()), '0);
        check("sb1_empty", q1.size() == 0, DW'(q1.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
